udma_lin_ch_arbiter: RTL and testbench
======================================

UDMA_LIN_CH_ARBITER -- requirements
Module: udma_lin_ch_arbiter

Interface
REQ-001 Parameter N_CH, default 19; number of linear TX channels arbitrated (UART, QSPIM data+cmd, I2C data+cmd, HYPER).
REQ-002 Parameter ADDR_W, default 32; L2 address width.
REQ-003 Parameter DEPTH, default 4; maximum outstanding L2 reads (in-flight ID FIFO depth), power of two, >=2.
REQ-004 Parameter ID_W, default $clog2(N_CH); channel ID width.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 ch_req_i  in  N_CH  per-channel read request.
REQ-008 ch_addr_i  in  N_CH*ADDR_W  per-channel address, channel k at bits [k*ADDR_W +: ADDR_W].
REQ-009 ch_size_i  in  N_CH*2  per-channel data size (0=byte, 1=half, 2=word).
REQ-010 ch_gnt_o  out  N_CH  one-hot grant; request accepted this cycle.
REQ-011 ch_rvalid_o  out  N_CH  one-hot read-data valid for the owning channel.
REQ-012 ch_rdata_o  out  32  read data, shared by all channels.
REQ-013 l2_req_o  out  1  L2 read request; l2_addr_o  out  ADDR_W; l2_size_o  out  2.
REQ-014 l2_gnt_i  in  1  L2 accepts request; l2_rvalid_i  in  1; l2_rdata_i  in  32.
REQ-015 err_o  out  1  one-cycle pulse on protocol error.

Function
REQ-016 Winner: round-robin over asserted ch_req_i, search from pointer rr_ptr upward, wrapping N_CH-1 -> 0.
REQ-017 Grant condition: any request AND stage free (stage_valid=0 or l2_gnt_i=1 this cycle) AND occ < DEPTH, where occ = fifo_count + stage_valid, no credit for a same-cycle pop.
REQ-018 On grant to channel k: ch_gnt_o[k]=1 same cycle (combinational); addr/size/ID k registered into output stage; rr_ptr <= (k+1) mod N_CH.
REQ-019 When the grant condition is false: ch_gnt_o all zero; rr_ptr unchanged.
REQ-020 Output stage: l2_req_o = stage_valid; l2_addr_o, l2_size_o driven from stage; stable while l2_req_o=1 and l2_gnt_i=0.
REQ-021 Latency: grant cycle N -> l2_req_o high in cycle N+1.
REQ-022 On l2_req_o & l2_gnt_i: stage ID pushed into ID FIFO; stage cleared unless refilled by same-cycle grant (back-to-back, no bubble).
REQ-023 On l2_rvalid_i with FIFO non-empty: pop head h; ch_rvalid_o[h]=1 same cycle; ch_rdata_o = l2_rdata_i (pass-through, always driven).
REQ-024 Responses returned strictly in request order.
REQ-025 Simultaneous push and pop: fifo_count unchanged; read/write pointers both advance, wrapping mod DEPTH.
REQ-026 l2_rvalid_i with FIFO empty: ch_rvalid_o all zero, no pop, err_o=1 for that cycle.
REQ-027 A channel dropping ch_req_i without a grant is legal; no state changes.
REQ-028 l2_gnt_i while l2_req_o=0 is ignored.

Reset
REQ-029 While rst_i=1 at a clock edge: rr_ptr=0, stage_valid=0, FIFO pointers and count=0.
REQ-030 During and after reset: l2_req_o=0, ch_gnt_o=0, ch_rvalid_o=0, err_o=0; l2_addr_o/l2_size_o = 0.
REQ-031 Reset mid-operation discards in-flight IDs; later l2_rvalid_i raises err_o.

Verification
REQ-032 Single: ch_req_i[3]=1, addr 0x1C000100, l2_gnt_i=1 -> ch_gnt_o[3] cycle 0, l2_req_o/addr 0x1C000100 cycle 1, l2_rvalid_i cycle 3 -> ch_rvalid_o[3]=1.
REQ-033 Fairness: channels 0, 5, 18 requesting continuously, l2_gnt_i=1 -> grant order 0,5,18,0,5,18; one grant per cycle.
REQ-034 Backpressure: l2_gnt_i=0 for 5 cycles -> l2_addr_o stable; exactly one further grant taken, then none until l2_gnt_i=1.
REQ-035 Outstanding limit: 4 requests granted, no l2_rvalid_i -> occ=4, no 5th grant; one l2_rvalid_i -> grant resumes next cycle.
REQ-036 Ordering/error: grants to channels 7, 2 then two l2_rvalid_i -> ch_rvalid_o[7] then [2]; third l2_rvalid_i -> err_o=1, ch_rvalid_o=0.
REQ-037 Reset with 2 in flight -> all outputs 0 next cycle, rr_ptr=0; subsequent l2_rvalid_i -> err_o=1.

Source files
------------

// File: rtl/udma_lin_ch_arbiter.sv
// Round-robin arbiter that funnels the uDMA linear TX channels onto one L2 read port
// and returns read data to the issuing channel in request order.
module udma_lin_ch_arbiter #(
    parameter int N_CH   = 19,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int ID_W   = $clog2(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          ch_req_i,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
    input  logic [N_CH*2-1:0]        ch_size_i,
    output logic [N_CH-1:0]          ch_gnt_o,
    output logic [N_CH-1:0]          ch_rvalid_o,
    output logic [31:0]              ch_rdata_o,
    output logic                     l2_req_o,
    output logic [ADDR_W-1:0]        l2_addr_o,
    output logic [1:0]               l2_size_o,
    input  logic                     l2_gnt_i,
    input  logic                     l2_rvalid_i,
    input  logic [31:0]              l2_rdata_i,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]   rr_ptr;
    logic              stage_valid;
    logic [ADDR_W-1:0] stage_addr;
    logic [1:0]        stage_size;
    logic [ID_W-1:0]   stage_id;

    logic [ID_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W:0]     scan_idx;
    logic [CNT_W:0]    occ;
    logic              fifo_empty;
    logic              grant;
    logic              push;
    logic              pop;

    // Scan from rr_ptr upward with wrap; the first asserted request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(N_CH)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_CH);
            end
            if (!win_found && ch_req_i[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // A pop in the same cycle gives no credit: occupancy counts the stage as well.
    assign occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid};
    assign fifo_empty = (fifo_count == '0);
    assign grant      = !rst_i && win_found && (!stage_valid || l2_gnt_i)
                        && (occ < (CNT_W+1)'(DEPTH));
    assign push       = stage_valid && l2_gnt_i;
    assign pop        = !rst_i && l2_rvalid_i && !fifo_empty;

    assign ch_gnt_o    = grant ? (N_CH'(1) << win_id) : '0;
    assign ch_rvalid_o = pop ? (N_CH'(1) << fifo_mem[rd_ptr]) : '0;
    assign ch_rdata_o  = l2_rdata_i;
    assign err_o       = !rst_i && l2_rvalid_i && fifo_empty;

    assign l2_req_o  = stage_valid;
    assign l2_addr_o = stage_addr;
    assign l2_size_o = stage_size;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_size  <= '0;
            stage_id    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            // A fresh grant refills the stage in the same cycle it is accepted.
            if (grant) begin
                rr_ptr      <= (win_id == ID_W'(N_CH-1)) ? '0 : win_id + 1'b1;
                stage_valid <= 1'b1;
                stage_addr  <= ch_addr_i[win_id*ADDR_W +: ADDR_W];
                stage_size  <= ch_size_i[win_id*2 +: 2];
                stage_id    <= win_id;
            end else if (push) begin
                stage_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= stage_id;
        end
    end

endmodule

// File: tb/tb_udma_lin_ch_arbiter.sv
// Directed bench for udma_lin_ch_arbiter; granted channel IDs go into a scoreboard
// queue and are matched against ch_rvalid_o when read data comes back.
module tb_udma_lin_ch_arbiter;

    localparam int N_CH   = 19;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N_CH-1:0]        ch_req;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*2-1:0]      ch_size;
    logic [N_CH-1:0]        ch_gnt_o;
    logic [N_CH-1:0]        ch_rvalid_o;
    logic [31:0]            ch_rdata_o;
    logic                   l2_req_o;
    logic [ADDR_W-1:0]      l2_addr_o;
    logic [1:0]             l2_size_o;
    logic                   l2_gnt_i;
    logic                   l2_rvalid_i;
    logic [31:0]            l2_rdata_i;
    logic                   err_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    udma_lin_ch_arbiter #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ch_req_i    (ch_req),
        .ch_addr_i   (ch_addr),
        .ch_size_i   (ch_size),
        .ch_gnt_o    (ch_gnt_o),
        .ch_rvalid_o (ch_rvalid_o),
        .ch_rdata_o  (ch_rdata_o),
        .l2_req_o    (l2_req_o),
        .l2_addr_o   (l2_addr_o),
        .l2_size_o   (l2_size_o),
        .l2_gnt_i    (l2_gnt_i),
        .l2_rvalid_i (l2_rvalid_i),
        .l2_rdata_i  (l2_rdata_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] addr_of(int k);
        return (k == 3) ? 32'h1C00_0100 : 32'h1C01_0000 + 32'(k * 4);
    endfunction

    function automatic logic [1:0] size_of(int k);
        return 2'(k % 3);
    endfunction

    function automatic logic [N_CH-1:0] oh(int k);
        logic [N_CH-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check_output(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(logic [N_CH-1:0] req, logic gnt, logic rvalid, logic [31:0] rdata);
        ch_req      = req;
        l2_gnt_i    = gnt;
        l2_rvalid_i = rvalid;
        l2_rdata_i  = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // exp_k < 0 means no grant is expected this cycle.
    task automatic check_grant(string tag, int exp_k);
        check_output(tag, 64'(ch_gnt_o), (exp_k < 0) ? 64'h0 : 64'(oh(exp_k)));
        if (exp_k >= 0) exp_q.push_back(exp_k);
    endtask

    task automatic check_response(string tag, logic [31:0] rdata);
        int k;
        if (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            check_output({tag, "_rvalid"}, 64'(ch_rvalid_o), 64'(oh(k)));
            check_output({tag, "_err"}, 64'(err_o), 64'h0);
            check_output({tag, "_rdata"}, 64'(ch_rdata_o), 64'(rdata));
        end else begin
            check_output({tag, "_rvalid_empty"}, 64'(ch_rvalid_o), 64'h0);
            check_output({tag, "_err_empty"}, 64'(err_o), 64'h1);
        end
    endtask

    initial begin
        int seq[3];
        int k;
        int prev_k;
        logic [31:0] rd;

        seq = '{0, 5, 18};
        for (int i = 0; i < N_CH; i++) begin
            ch_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
            ch_size[i*2 +: 2]           = size_of(i);
        end

        // Reset with live inputs: every output must stay quiet.
        rst_i = 1'b1;
        apply_stimulus(oh(2), 1'b1, 1'b1, 32'hDEAD_BEEF);
        next_cycle();
        settle();
        check_output("reset_gnt", 64'(ch_gnt_o), 64'h0);
        check_output("reset_rvalid", 64'(ch_rvalid_o), 64'h0);
        check_output("reset_err", 64'(err_o), 64'h0);
        check_output("reset_l2_req", 64'(l2_req_o), 64'h0);
        check_output("reset_l2_addr", 64'(l2_addr_o), 64'h0);
        check_output("reset_l2_size", 64'(l2_size_o), 64'h0);
        next_cycle();
        rst_i = 1'b0;
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        settle();
        check_output("post_reset_l2_req", 64'(l2_req_o), 64'h0);
        next_cycle();

        // Fairness among channels 0, 5, 18 with continuous drain.
        prev_k = -1;
        for (int c = 0; c < 8; c++) begin
            k  = (c < 6) ? seq[c % 3] : -1;
            rd = 32'h5000_0000 + 32'(c);
            apply_stimulus((c < 6) ? (oh(0) | oh(5) | oh(18)) : '0, 1'b1, c >= 2, rd);
            settle();
            check_grant("fair_gnt", k);
            if (prev_k >= 0) begin
                check_output("fair_l2_req", 64'(l2_req_o), 64'h1);
                check_output("fair_l2_addr", 64'(l2_addr_o), 64'(addr_of(prev_k)));
            end
            if (c >= 2) check_response("fair_rsp", rd);
            prev_k = k;
            next_cycle();
        end

        // Single request on channel 3.
        apply_stimulus(oh(3), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("single_gnt", 3);
        check_output("single_l2_req0", 64'(l2_req_o), 64'h0);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        settle();
        check_output("single_l2_req1", 64'(l2_req_o), 64'h1);
        check_output("single_l2_addr", 64'(l2_addr_o), 64'h1C00_0100);
        check_output("single_l2_size", 64'(l2_size_o), 64'(size_of(3)));
        next_cycle();
        settle();
        check_output("single_l2_req2", 64'(l2_req_o), 64'h0);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b1, 32'hA5A5_0003);
        settle();
        check_response("single_rsp", 32'hA5A5_0003);
        next_cycle();

        // Backpressure: stage holds channel 9 while L2 refuses.
        apply_stimulus(oh(9), 1'b0, 1'b0, 32'h0);
        settle();
        check_grant("bp_gnt_first", 9);
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            apply_stimulus(oh(10), 1'b0, 1'b0, 32'h0);
            settle();
            check_grant("bp_gnt_held", -1);
            check_output("bp_l2_req", 64'(l2_req_o), 64'h1);
            check_output("bp_l2_addr", 64'(l2_addr_o), 64'(addr_of(9)));
            next_cycle();
        end
        apply_stimulus(oh(10), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("bp_gnt_resume", 10);
        check_output("bp_l2_addr_last", 64'(l2_addr_o), 64'(addr_of(9)));
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        settle();
        check_output("bp_l2_addr_next", 64'(l2_addr_o), 64'(addr_of(10)));
        check_output("bp_l2_size_next", 64'(l2_size_o), 64'(size_of(10)));
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            rd = 32'h6000_0000 + 32'(c);
            apply_stimulus('0, 1'b1, 1'b1, rd);
            settle();
            if (c == 0) check_output("bp_l2_req_idle", 64'(l2_req_o), 64'h0);
            check_response("bp_rsp", rd);
            next_cycle();
        end

        // Outstanding limit: channel 12 requests continuously.
        for (int c = 0; c < 7; c++) begin
            rd = 32'h7000_0000 + 32'(c);
            apply_stimulus(oh(12), 1'b1, c == 5, rd);
            settle();
            check_grant("lim_gnt", (c == 4 || c == 5) ? -1 : 12);
            if (c == 5) check_response("lim_rsp", rd);
            next_cycle();
        end
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            rd = 32'h7100_0000 + 32'(c);
            apply_stimulus('0, 1'b1, 1'b1, rd);
            settle();
            check_response("lim_drain", rd);
            next_cycle();
        end

        // Ordering then a response with nothing outstanding.
        apply_stimulus(oh(7), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("ord_gnt7", 7);
        next_cycle();
        apply_stimulus(oh(2), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("ord_gnt2", 2);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            rd = 32'h8000_0000 + 32'(c);
            apply_stimulus('0, 1'b1, 1'b1, rd);
            settle();
            check_response("ord_rsp", rd);
            next_cycle();
        end
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        settle();
        check_output("ord_err_clear", 64'(err_o), 64'h0);
        next_cycle();

        // Reset with two reads in flight.
        apply_stimulus(oh(1), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("rst_gnt1", 1);
        next_cycle();
        apply_stimulus(oh(4), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("rst_gnt4", 4);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        rst_i = 1'b1;
        apply_stimulus(oh(6), 1'b1, 1'b1, 32'h9000_0000);
        settle();
        check_output("rst_mid_gnt", 64'(ch_gnt_o), 64'h0);
        check_output("rst_mid_rvalid", 64'(ch_rvalid_o), 64'h0);
        check_output("rst_mid_err", 64'(err_o), 64'h0);
        exp_q.delete();
        next_cycle();
        rst_i = 1'b0;
        apply_stimulus('0, 1'b1, 1'b1, 32'h9000_0001);
        settle();
        check_output("rst_after_l2_req", 64'(l2_req_o), 64'h0);
        check_output("rst_after_l2_addr", 64'(l2_addr_o), 64'h0);
        check_output("rst_after_l2_size", 64'(l2_size_o), 64'h0);
        check_output("rst_after_gnt", 64'(ch_gnt_o), 64'h0);
        check_response("rst_after_rsp", 32'h9000_0001);
        next_cycle();
        apply_stimulus(oh(0) | oh(17), 1'b1, 1'b0, 32'h0);
        settle();
        check_grant("rst_rr_ptr", 0);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);
        settle();
        check_output("rst_l2_addr0", 64'(l2_addr_o), 64'(addr_of(0)));
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b1, 32'h9000_0002);
        settle();
        check_response("rst_final_rsp", 32'h9000_0002);
        next_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
